// File: rtl/hazard_pkg.sv
// Shared types for the pipeline interlock: FSM state encoding and the
// scoreboard entry describing one in-flight register writer.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
  } sb_entry_t;

  localparam sb_entry_t SB_NOP = '{valid: 1'b0, rd: 5'd0, we: 1'b0};

  localparam int unsigned SB_DEPTH = 3;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-deep shift register of in-flight writers (EX, MEM, WB) and the
// two register lookup ports used for RAW detection in ID.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter bit WB_BYPASS       = 1'b0,
  parameter bit ZERO_REG_IGNORE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       stall_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_regwrite_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic       match_rs_o,
  output logic       match_rt_o
);

  sb_entry_t sb_q [SB_DEPTH];
  sb_entry_t sb_d [SB_DEPTH];

  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r);
    return e.valid & e.we & (e.rd == r) & ((r != 5'd0) | ~ZERO_REG_IGNORE);
  endfunction

  // A write-first register file lets the WB writer satisfy the reader itself.
  always_comb begin
    match_rs_o = sb_hit(sb_q[0], rs_i) | sb_hit(sb_q[1], rs_i) |
                 (~WB_BYPASS & sb_hit(sb_q[2], rs_i));
    match_rt_o = sb_hit(sb_q[0], rt_i) | sb_hit(sb_q[1], rt_i) |
                 (~WB_BYPASS & sb_hit(sb_q[2], rt_i));
  end

  // A taken branch kills EX and the branch slot; a stall shifts in a bubble.
  always_comb begin
    sb_d[2] = sb_q[1];
    sb_d[1] = sb_q[0];
    sb_d[0] = SB_NOP;
    if (flush_i) begin
      sb_d[1] = SB_NOP;
      sb_d[0] = SB_NOP;
    end else begin
      sb_d[1] = sb_q[0];
      sb_d[0] = '{valid: id_valid_i & ~stall_i, rd: id_rd_i, we: id_regwrite_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= SB_NOP;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= sb_d[i];
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock and flush sequencer: stalls PC/IF-ID on RAW hazards, flushes
// younger stages on a taken branch, and counts stall and flush cycles.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter bit          WB_BYPASS       = 1'b0,
  parameter int unsigned CNT_W           = 16,
  parameter bit          ZERO_REG_IGNORE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             br_taken_mem,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             match_rs;
  logic             match_rt;
  logic             stall_c;
  logic             flush_c;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  hazard_scoreboard #(
    .WB_BYPASS       (WB_BYPASS),
    .ZERO_REG_IGNORE (ZERO_REG_IGNORE)
  ) u_sb (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush_c),
    .stall_i       (stall_c),
    .id_valid_i    (id_valid),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .rs_i          (id_rs),
    .rt_i          (id_rt),
    .match_rs_o    (match_rs),
    .match_rt_o    (match_rt)
  );

  assign stall_c = id_valid & ((id_use_rs & match_rs) | (id_use_rt & match_rt));
  assign flush_c = br_taken_mem;

  // Flush outranks stall: the stalled instruction is on the wrong path anyway.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (flush_c) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (stall_c) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN, ST_STALL, ST_FLUSH: begin
        if (flush_c) begin
          state_d = ST_FLUSH;
        end else if (stall_c) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c & ~flush_c & (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_c & (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table-driven cycle vectors on a default build plus
// hand sequences for WB bypass, counter saturation and async reset.
module tb_hazard_ctrl;

  localparam logic [4:0] CTL_RUN   = 5'b11000;
  localparam logic [4:0] CTL_STALL = 5'b00010;
  localparam logic [4:0] CTL_FLUSH = 5'b11111;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] rd;
    logic       we;
    logic       br;
    logic [4:0] ctl;
    logic [1:0] st;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_valid = 1'b0, a_use_rs = 1'b0, a_use_rt = 1'b0, a_we = 1'b0, a_br = 1'b0;
  logic [4:0] a_rs = 5'd0, a_rt = 5'd0, a_rd = 5'd0;
  logic       a_pcw, a_ifw, a_iff, a_idf, a_exf;
  logic [1:0] a_state;
  logic [15:0] a_sc, a_fc;

  logic       b_valid = 1'b0, b_use_rs = 1'b0, b_use_rt = 1'b0, b_we = 1'b0, b_br = 1'b0;
  logic [4:0] b_rs = 5'd0, b_rt = 5'd0, b_rd = 5'd0;
  logic       b_pcw, b_ifw, b_iff, b_idf, b_exf;
  logic [1:0] b_state;
  logic [3:0] b_sc, b_fc;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_valid(a_valid), .id_rs(a_rs), .id_rt(a_rt),
    .id_use_rs(a_use_rs), .id_use_rt(a_use_rt), .id_rd(a_rd), .id_regwrite(a_we),
    .br_taken_mem(a_br), .pc_write(a_pcw), .ifid_write(a_ifw), .ifid_flush(a_iff),
    .idex_flush(a_idf), .exmem_flush(a_exf), .state(a_state),
    .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(b_valid), .id_rs(b_rs), .id_rt(b_rt),
    .id_use_rs(b_use_rs), .id_use_rt(b_use_rt), .id_rd(b_rd), .id_regwrite(b_we),
    .br_taken_mem(b_br), .pc_write(b_pcw), .ifid_write(b_ifw), .ifid_flush(b_iff),
    .idex_flush(b_idf), .exmem_flush(b_exf), .state(b_state),
    .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  task automatic add(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] rd,
                     input logic we, input logic br, input logic [4:0] ctl,
                     input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
    vec_t t;
    t.valid = v; t.rs = rs; t.rt = rt; t.use_rs = urs; t.use_rt = urt;
    t.rd = rd; t.we = we; t.br = br; t.ctl = ctl; t.st = st; t.sc = sc; t.fc = fc;
    vecs.push_back(t);
  endtask

  task automatic drive_a(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic we, input logic br);
    a_valid = v; a_rs = rs; a_rt = rt; a_use_rs = urs; a_use_rt = urt;
    a_rd = rd; a_we = we; a_br = br;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    exp_t got;

    // lw $8 then add $9,$8,$8: three stall cycles with no WB bypass
    add(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, CTL_RUN,   2'd0, 16'd0, 16'd0);
    add(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, CTL_STALL, 2'd0, 16'd0, 16'd0);
    add(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, CTL_STALL, 2'd1, 16'd1, 16'd0);
    add(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, CTL_STALL, 2'd1, 16'd2, 16'd0);
    add(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, CTL_RUN,   2'd1, 16'd3, 16'd0);
    for (int i = 0; i < 3; i++)
      add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_RUN, 2'd0, 16'd3, 16'd0);
    // writer of $0 then reader of $0: never a hazard
    add(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, CTL_RUN,   2'd0, 16'd3, 16'd0);
    add(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, CTL_RUN,   2'd0, 16'd3, 16'd0);
    // taken branch while EX writes $5 and ID reads $5
    add(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, CTL_FLUSH, 2'd0, 16'd3, 16'd0);
    add(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, CTL_RUN,   2'd2, 16'd3, 16'd1);
    // stall on $3 interrupted by a taken branch
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, CTL_RUN,   2'd0, 16'd3, 16'd1);
    add(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, CTL_STALL, 2'd0, 16'd3, 16'd1);
    add(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, CTL_FLUSH, 2'd1, 16'd4, 16'd1);
    add(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, CTL_RUN,   2'd2, 16'd4, 16'd2);
    add(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, CTL_RUN,   2'd0, 16'd4, 16'd2);
    // we=0 writer never matches; rs==rt reader counts one hazard per cycle
    add(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0, CTL_RUN,  2'd0, 16'd4, 16'd2);
    add(1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, CTL_RUN, 2'd0, 16'd4, 16'd2);
    add(1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, CTL_STALL, 2'd0, 16'd4, 16'd2);
    add(1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, CTL_STALL, 2'd1, 16'd5, 16'd2);
    add(1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, CTL_STALL, 2'd1, 16'd6, 16'd2);
    add(1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, CTL_RUN,   2'd1, 16'd7, 16'd2);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_RUN,   2'd0, 16'd7, 16'd2);
    // back-to-back taken branches: FLUSH -> FLUSH -> RUN
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, CTL_FLUSH, 2'd0, 16'd7, 16'd2);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, CTL_FLUSH, 2'd2, 16'd7, 16'd3);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_RUN,   2'd2, 16'd7, 16'd4);
    add(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, CTL_RUN,   2'd0, 16'd7, 16'd4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl_a", {27'd0, a_pcw, a_ifw, a_iff, a_idf, a_exf}, {27'd0, CTL_RUN});
    chk("rst_state_a", {30'd0, a_state}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive_a(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].use_rs, vecs[i].use_rt,
              vecs[i].rd, vecs[i].we, vecs[i].br);
      exp_q.push_back('{ctl: vecs[i].ctl, st: vecs[i].st, sc: vecs[i].sc, fc: vecs[i].fc});
      @(negedge clk);
      e = exp_q.pop_front();
      got = '{ctl: {a_pcw, a_ifw, a_iff, a_idf, a_exf}, st: a_state, sc: a_sc, fc: a_fc};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL vec%0d: got ctl=%b st=%0d sc=%0d fc=%0d expected ctl=%b st=%0d sc=%0d fc=%0d",
                 i, got.ctl, got.st, got.sc, got.fc, e.ctl, e.st, e.sc, e.fc);
      end
    end
    @(posedge clk);
    #1;
    drive_a(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // WB bypass build: two stalls per load-use pair; counter saturates at 15
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      #1;
      b_valid = 1'b1; b_rs = 5'd1; b_use_rs = 1'b0; b_rd = 5'd8; b_we = 1'b1;
      @(negedge clk);
      chk("b_writer_pcw", {31'd0, b_pcw}, 32'd1);
      for (int j = 0; j < 3; j++) begin
        @(posedge clk);
        #1;
        b_valid = 1'b1; b_rs = 5'd8; b_use_rs = 1'b1; b_rd = 5'd0; b_we = 1'b0;
        @(negedge clk);
        chk("b_reader_pcw", {31'd0, b_pcw}, (j < 2) ? 32'd0 : 32'd1);
        if (j == 2) begin
          chk("b_stall_cnt", {28'd0, b_sc}, (2 + 2 * k > 15) ? 32'd15 : 32'(2 + 2 * k));
          chk("b_state", {30'd0, b_state}, 32'd1);
        end
      end
    end
    @(posedge clk);
    #1;
    b_valid = 1'b0; b_use_rs = 1'b0;

    // async reset in the middle of a stall
    @(posedge clk);
    #1;
    drive_a(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive_a(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_pcw", {31'd0, a_pcw}, 32'd0);
    chk("pre_rst_state", {30'd0, a_state}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_state", {30'd0, a_state}, 32'd0);
    chk("async_rst_sc", {16'd0, a_sc}, 32'd0);
    chk("async_rst_fc", {16'd0, a_fc}, 32'd0);
    chk("async_rst_ctl", {27'd0, a_pcw, a_ifw, a_iff, a_idf, a_exf}, {27'd0, CTL_RUN});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pcw", {31'd0, a_pcw}, 32'd1);
    chk("post_rst_state", {30'd0, a_state}, 32'd0);
    chk("post_rst_sc", {16'd0, a_sc}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
